// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin2bcd_pkg;

  // Controller states: wait for start, shift-subtract one digit, latch digit
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    STORE  = 2'd2
  } state_t;

  // Each pass divides the running quotient by this
  localparam int DIVISOR = 10;

  // Bits per packed BCD digit
  localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_div10_step.sv
// One restoring divide-by-ten step: shift a bit into the remainder, subtract 10 if it fits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module bcd_div10_step
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [BCD_W-1:0] rem_out,
  output logic             q_bit
);

  logic [BCD_W:0] trial;
  logic [BCD_W:0] diff;

  // Remainder stays <= 9, so the 5-bit trial is < 20 and one subtraction suffices
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - (BCD_W+1)'(DIVISOR);
    q_bit   = (trial >= (BCD_W+1)'(DIVISOR));
    rem_out = q_bit ? diff[BCD_W-1:0] : trial[BCD_W-1:0];
  end

endmodule

// File: rtl/bin2bcd_converter.sv
// Converts a BIN_WIDTH-bit unsigned value to DIGITS packed BCD digits by serial division by ten.
// Latency: done pulses in the cycle after edge DIGITS*(BIN_WIDTH+1), counting the accept edge as 0.
// Backpressure: start is only sampled in IDLE; start while busy is dropped. Optional macro: BIN2BCD_BLANK_EN.
module bin2bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_WIDTH-1:0]      value,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      overflow,
  output logic [DIGITS-1:0]         blank
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                    state;
  logic [BIN_WIDTH-1:0]      q;
  logic [BCD_W-1:0]          r;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [BCD_W*DIGITS-1:0]   shadow;

  logic [BCD_W-1:0]          r_nxt;
  logic                      q_bit;
  logic [BCD_W*DIGITS-1:0]   shadow_nxt;
  logic                      ovf_nxt;

  bcd_div10_step u_step (
    .rem_in  (r),
    .bit_in  (q[BIN_WIDTH-1]),
    .rem_out (r_nxt),
    .q_bit   (q_bit)
  );

  // Shadow digits with the current remainder dropped into the slot being stored
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        shadow_nxt[BCD_W*i +: BCD_W] = r;
      end
    end
    // After the last pass q is value / 10^DIGITS; anything left means it did not fit
    ovf_nxt = |q;
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;

  // Blank a digit when it and every more significant digit are zero; units never blank
  always_comb begin
    logic all_zero;
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero & (shadow_nxt[BCD_W*i +: BCD_W] == '0);
      blank_nxt[i] = all_zero & ~ovf_nxt;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  // Control FSM and datapath registers; results only move on the completion edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      q        <= '0;
      r        <= '0;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q     <= value;
            r     <= '0;
            cnt   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r   <= r_nxt;
          q   <= {q[BIN_WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_WIDTH - 1)) begin
            state <= STORE;
          end
        end
        STORE: begin
          shadow <= shadow_nxt;
          r      <= '0;
          cnt    <= '0;
          if (idx != IDX_W'(DIGITS - 1)) begin
            idx   <= idx + 1'b1;
            state <= DIVIDE;
          end else begin
            bcd      <= shadow_nxt;
            overflow <= ovf_nxt;
`ifdef BIN2BCD_BLANK_EN
            blank_q  <= blank_nxt;
`endif
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter against an arithmetic reference model.
// Latency: expects done exactly DIGITS*(BIN_WIDTH+1) edges after the accept edge.
// Backpressure: exercises start-while-busy, start held high and mid-conversion reset.
module tb_bin2bcd_converter;

  localparam int DIGITS    = 4;
  localparam int BIN_WIDTH = 14;
  localparam int LAT       = DIGITS * (BIN_WIDTH + 1);
  localparam int LIMIT     = 10 ** DIGITS;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [BIN_WIDTH-1:0]    value;
  logic                    busy;
  logic                    done;
  logic [4*DIGITS-1:0]     bcd;
  logic                    overflow;
  logic [DIGITS-1:0]       blank;

  int total;
  int bad;

  bin2bcd_converter #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of value mod 10^DIGITS, packed as hex nibbles
  function automatic logic [31:0] ref_bcd(input int v);
    int m;
    logic [31:0] res;
    m   = v % LIMIT;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return res;
  endfunction

  function automatic logic [31:0] ref_ovf(input int v);
    return (v >= LIMIT) ? 32'd1 : 32'd0;
  endfunction

  // Digit i (i>=1) is blank when the in-range value is below 10^i
  function automatic logic [31:0] ref_blank(input int v);
    logic [31:0] res;
    res = '0;
`ifdef BIN2BCD_BLANK_EN
    if (v < LIMIT) begin
      for (int i = 1; i < DIGITS; i++) begin
        if (v < 10 ** i) res[i] = 1'b1;
      end
    end
`endif
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done after an accept edge; returns edges elapsed, checks busy and result stability
  task automatic wait_done(input string tag, input logic [31:0] old_bcd, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (lat == LAT - 1) begin
        chk({tag, "_busy_late"}, 32'(busy), 32'd1);
        chk({tag, "_bcd_hold"}, 32'(bcd), old_bcd);
      end
    end
  endtask

  task automatic check_result(input string tag, input int v, input int lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), ref_bcd(v));
    chk({tag, "_ovf"}, 32'(overflow), ref_ovf(v));
    chk({tag, "_blank"}, 32'(blank), ref_blank(v));
  endtask

  task automatic convert(input string tag, input int v);
    int lat;
    logic [31:0] old;
    old   = 32'(bcd);
    value = BIN_WIDTH'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(tag, old, lat);
    check_result(tag, v, lat);
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int v;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    value = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    rst = 1'b1;
    tick();

    convert("v1234", 1234);
    convert("v0", 0);
    convert("v16383", 16383);
    convert("v9999", 9999);
    convert("v10000", 10000);
    convert("v1234b", 1234);

    // start pulse at edge 20 of a busy conversion must be dropped
    value = BIN_WIDTH'(42);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e < 20; e++) tick();
    value = BIN_WIDTH'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 20;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check_result("ign", 42, lat);
    seen = 0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("ign_no_second", seen, 0);

    // reset asserted at edge 30 of a conversion
    value = BIN_WIDTH'(8765);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e < 30; e++) tick();
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bcd", 32'(bcd), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_blank", 32'(blank), 32'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("arst_no_done", seen, 0);
    convert("after_rst", 5);

    // start held high: second conversion accepted on the edge where done is high
    value = BIN_WIDTH'(321);
    start = 1'b1;
    tick();
    value = BIN_WIDTH'(9087);
    wait_done("held1", 32'(bcd), lat);
    check_result("held1", 321, lat);
    tick();
    chk("held_reaccept_busy", 32'(busy), 32'd1);
    chk("held_reaccept_done", 32'(done), 32'd0);
    start = 1'b0;
    wait_done("held2", 32'(bcd), lat);
    check_result("held2", 9087, lat);
    tick();

    // randomized values, biased toward the in-range set
    for (int n = 0; n < 24; n++) begin
      if (n % 3 == 0) v = int'($urandom_range(0, (1 << BIN_WIDTH) - 1));
      else if (n % 3 == 1) v = int'($urandom_range(0, 99));
      else v = int'($urandom_range(0, LIMIT - 1));
      convert($sformatf("rnd%0d_%0d", n, v), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
